// File: rtl/dac_spi_master.sv
// rtl/dac_spi_master.sv - multi-channel SPI master for serial DACs, one sync frame per channel
// Optional: define DAC_SPI_AUTO_EN for continuous mode (re-latch ch_data after every transfer).
module dac_spi_master #(
  parameter int WORD_W  = 16,
  parameter int NUM_CH  = 2,
  parameter int CLK_DIV = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH*WORD_W-1:0] ch_data,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_sclk,
  output logic                     dac_sout,
  output logic                     dac_sync
);
  localparam int TOP   = NUM_CH*WORD_W-1;
  localparam int PH_W  = $clog2(2*CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PH_W-1:0]  H_LAST   = PH_W'(CLK_DIV-1);
  localparam logic [PH_W-1:0]  G_LAST   = PH_W'(2*CLK_DIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W-1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH-1);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, GAP} state_t;

  state_t           state;
  logic [PH_W-1:0]  ph;
  logic [BIT_W-1:0] bit_cnt;
  logic [CH_W-1:0]  ch;
  logic [TOP:0]     sreg;
  logic [TOP:0]     ch_rev;

  // Channel 0 sits at the top so one continuous left shift walks every frame in order.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_rev
    assign ch_rev[(NUM_CH-c)*WORD_W-1 -: WORD_W] = ch_data[c*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ph       <= '0;
      bit_cnt  <= '0;
      ch       <= '0;
      sreg     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dac_sclk <= 1'b1;
      dac_sout <= 1'b0;
      dac_sync <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg     <= ch_rev;
            ch       <= '0;
            ph       <= '0;
            busy     <= 1'b1;
            dac_sync <= 1'b0;
            dac_sclk <= 1'b1;
            dac_sout <= ch_data[WORD_W-1];
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (ph == H_LAST) begin
            ph       <= '0;
            bit_cnt  <= '0;
            dac_sclk <= 1'b0;
            state    <= LOW;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        LOW: begin
          if (ph == H_LAST) begin
            ph       <= '0;
            dac_sclk <= 1'b1;
            state    <= HIGH;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        HIGH: begin
          if (ph == H_LAST) begin
            ph   <= '0;
            sreg <= sreg << 1;
            if (bit_cnt == BIT_LAST) begin
              dac_sync <= 1'b1;
              dac_sout <= 1'b0;
              state    <= GAP;
            end else begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              dac_sout <= sreg[TOP-1];
              dac_sclk <= 1'b0;
              state    <= LOW;
            end
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        GAP: begin
          if (ph == G_LAST) begin
            ph <= '0;
            if (ch != CH_LAST) begin
              ch       <= ch + CH_W'(1);
              dac_sync <= 1'b0;
              dac_sout <= sreg[TOP];
              state    <= LOAD;
            end else begin
              done <= 1'b1;
`ifdef DAC_SPI_AUTO_EN
              sreg     <= ch_rev;
              ch       <= '0;
              dac_sync <= 1'b0;
              dac_sout <= ch_data[WORD_W-1];
              state    <= LOAD;
`else
              busy  <= 1'b0;
              state <= IDLE;
`endif
            end
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_master.sv
// tb/tb_dac_spi_master.sv - directed self-checking bench for dac_spi_master
// Build with DAC_SPI_AUTO_EN to exercise continuous mode (24-bit, 4 channels, divider 1).
module tb_dac_spi_master;
`ifdef DAC_SPI_AUTO_EN
  localparam int W = 24, N = 4, H = 1;
`else
  localparam int W = 16, N = 2, H = 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N*W-1:0] ch_data = '0;
  logic         busy, done, dac_sclk, dac_sout, dac_sync;

  int tests = 0;
  int fails = 0;
  int pcount = 0;

  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;
  logic [31:0] cur = '0;
  int          nbits = 0;
  int          rise_cyc = -1;
  logic [31:0] frames[$];
  int          fbits[$];
  int          gaps[$];
  int          falls[$];
  int          dones[$];

  dac_spi_master #(.WORD_W(W), .NUM_CH(N), .CLK_DIV(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ch_data(ch_data),
    .busy(busy), .done(done), .dac_sclk(dac_sclk), .dac_sout(dac_sout), .dac_sync(dac_sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pcount <= pcount + 1;

  // Pin monitor: cycle numbers are "edge count + 1", i.e. the period following that edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sclk <= 1'b1;
      prev_sync <= 1'b1;
      cur       <= '0;
      nbits     <= 0;
      rise_cyc  <= -1;
    end else begin
      prev_sclk <= dac_sclk;
      prev_sync <= dac_sync;
      if (dac_sclk && !prev_sclk && !dac_sync) begin
        cur   <= {cur[30:0], dac_sout};
        nbits <= nbits + 1;
      end
      if (dac_sync && !prev_sync) begin
        frames.push_back(cur);
        fbits.push_back(nbits);
        cur      <= '0;
        nbits    <= 0;
        rise_cyc <= pcount + 1;
      end
      if (!dac_sync && prev_sync) begin
        falls.push_back(pcount + 1);
        if (rise_cyc >= 0) gaps.push_back(pcount + 1 - rise_cyc);
      end
      if (done) dones.push_back(pcount + 1);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    frames.delete(); fbits.delete(); gaps.delete(); falls.delete(); dones.delete();
  endtask

  // Leaves the bench 1 time unit after the edge that ends the done cycle.
  task automatic wait_done(input int budget, output int ok, output int busy_at);
    ok = 0;
    busy_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        busy_at = int'(busy);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int k);
    start = 1'b1;
    @(posedge clk);
    #1;
    k = pcount;
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef DAC_SPI_AUTO_EN
  function automatic logic [N*W-1:0] pack4(input logic [23:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  initial begin
    int k, ok, b;
    logic [23:0] exp_f[12];
    exp_f = '{24'hA50F3C, 24'h123456, 24'hFEDCBA, 24'h800001,
              24'h0F0F0F, 24'h5A5A5A, 24'hC3C3C3, 24'h000001,
              24'h7FFFFE, 24'h3CA5E1, 24'h010203, 24'hFFFFFF};
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("auto_reset_pins", {dac_sync, dac_sclk, dac_sout, busy, done}, 5'b11000);
    clear_mon();
    ch_data = pack4(exp_f[0], exp_f[1], exp_f[2], exp_f[3]);
    pulse_start(k);
    chk("auto_accept_busy", busy, 1'b1);
    chk("auto_accept_sout", dac_sout, 1'b1);
    step(9);
    ch_data = pack4(exp_f[4], exp_f[5], exp_f[6], exp_f[7]);
    start = 1'b1;
    wait_done(400, ok, b);
    chk("auto_done1_seen", ok, 1);
    chk("auto_done1_busy", b, 1);
    step(10);
    ch_data = pack4(exp_f[8], exp_f[9], exp_f[10], exp_f[11]);
    wait_done(400, ok, b);
    chk("auto_done2_seen", ok, 1);
    chk("auto_done2_busy", b, 1);
    start = 1'b0;
    wait_done(400, ok, b);
    chk("auto_done3_seen", ok, 1);
    chk("auto_done3_busy", b, 1);
    chk("auto_done_count", dones.size(), 3);
    chk("auto_done1_cycle", dones[0], k + 205);
    chk("auto_done_period1", dones[1] - dones[0], 204);
    chk("auto_done_period2", dones[2] - dones[1], 204);
    chk("auto_frames_min", frames.size() >= 12, 1'b1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("auto_frame%0d", i), frames[i], {8'h00, exp_f[i]});
      chk($sformatf("auto_bits%0d", i), fbits[i], 24);
    end
    chk("auto_gap", gaps[0], 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
`else
  initial begin
    int k, k2, ok, b;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_pins", {dac_sync, dac_sclk, dac_sout, busy, done}, 5'b11000);
    end
    step(1);

    // Single transfer.
    clear_mon();
    ch_data = {16'h3C5A, 16'h03A5};
    pulse_start(k);
    chk("t2_accept_busy", busy, 1'b1);
    chk("t2_accept_sync", dac_sync, 1'b0);
    chk("t2_accept_sclk", dac_sclk, 1'b1);
    chk("t2_accept_sout", dac_sout, 1'b0);
    wait_done(300, ok, b);
    chk("t2_done_seen", ok, 1);
    chk("t2_busy_in_done", b, 0);
    chk("t2_done_pulse", done, 1'b0);
    chk("t2_frames", frames.size(), 2);
    chk("t2_frame0", frames[0], 32'h03A5);
    chk("t2_frame1", frames[1], 32'h3C5A);
    chk("t2_bits0", fbits[0], 16);
    chk("t2_bits1", fbits[1], 16);
    chk("t2_gap", gaps[0], 4);
    chk("t2_done_cycle", dones[0], k + 141);

    // start while busy is ignored; ch_data changes do not leak into the transfer.
    clear_mon();
    pulse_start(k);
    step(9);
    ch_data = {16'hFFFF, 16'h0000};
    step(40);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(300, ok, b);
    chk("t3_done_seen", ok, 1);
    step(30);
    chk("t3_done_count", dones.size(), 1);
    chk("t3_done_cycle", dones[0], k + 141);
    chk("t3_frames", frames.size(), 2);
    chk("t3_frame0", frames[0], 32'h03A5);
    chk("t3_frame1", frames[1], 32'h3C5A);
    chk("t3_idle_busy", busy, 1'b0);

    // start held through done gives a back-to-back transfer.
    clear_mon();
    ch_data = {16'hA0F1, 16'h5E17};
    start = 1'b1;
    step(1);
    k = pcount;
    wait_done(300, ok, b);
    start = 1'b0;
    chk("t4_done1_seen", ok, 1);
    wait_done(300, ok, b);
    chk("t4_done2_seen", ok, 1);
    step(10);
    chk("t4_done_count", dones.size(), 2);
    chk("t4_done1_cycle", dones[0], k + 141);
    chk("t4_done2_cycle", dones[1], dones[0] + 141);
    chk("t4_falls", falls.size(), 4);
    chk("t4_refall", falls[2], dones[0] + 1);
    chk("t4_frames", frames.size(), 4);
    chk("t4_frame0", frames[0], 32'h5E17);
    chk("t4_frame1", frames[1], 32'hA0F1);
    chk("t4_frame2", frames[2], 32'h5E17);
    chk("t4_frame3", frames[3], 32'hA0F1);

    // Reset mid-transfer.
    clear_mon();
    ch_data = {16'h3C5A, 16'h03A5};
    pulse_start(k);
    step(29);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_pins", {dac_sync, dac_sclk, dac_sout, busy, done}, 5'b11000);
    step(2);
    rst_n = 1'b1;
    step(20);
    chk("t5_no_done", dones.size(), 0);
    chk("t5_no_frame", frames.size(), 0);
    clear_mon();
    pulse_start(k2);
    wait_done(300, ok, b);
    chk("t5_done_seen", ok, 1);
    chk("t5_done_cycle", dones[0], k2 + 141);
    chk("t5_frame0", frames[0], 32'h03A5);
    chk("t5_frame1", frames[1], 32'h3C5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
`endif
endmodule

// File: doc/dac_spi_master.md
# dac_spi_master

Parametrised multi-channel SPI master for serial DACs, the successor of the single-word DAC shift driver. One `start` pulse latches one data word per channel. The block then sends each word as its own SPI frame, one channel after another, with its own `sync` window for each frame. It generates a divided `dac_sclk` internally, reports `busy`/`done` to the waveform generator above it, and drives the DAC pins directly.

## Interface
- `WORD_W`, 16, bits per SPI frame (control byte plus data); ≥ 2.
- `NUM_CH`, 2, number of frames per transfer; ≥ 1.
- `CLK_DIV`, 2, `clk` cycles per `dac_sclk` half-period (H); ≥ 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  transfer request; sampled only in IDLE.
- `ch_data`  in  NUM_CH·WORD_W  channel c is `ch_data[(c+1)·WORD_W-1 : c·WORD_W]`; latched on accept.
- `busy`  out  1  high from the cycle after accept until the transfer ends.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `dac_sclk`  out  1  SPI clock; idles high.
- `dac_sout`  out  1  serial data, MSB first.
- `dac_sync`  out  1  active-low frame select.

## Operation
- States: IDLE, LOAD, LOW, HIGH, GAP. A channel index `ch` and a bit counter `bit` (counts 0..WORD_W-1) drive the transitions. A phase counter runs 0..H-1.
- Reset values (asynchronous, `rst_n`=0):
  - state=IDLE
  - `dac_sync`=1, `dac_sclk`=1, `dac_sout`=0
  - `busy`=0, `done`=0
  - counters and shift register = 0
- IDLE with `start`=1 (accept):
  - latch all of `ch_data`
  - set ch=0, load channel 0 into the shift register
  - go to LOAD
- LOAD, H cycles: `dac_sync`=0, `dac_sclk`=1, `dac_sout`=MSB. Then go to LOW with bit=0.
- LOW, H cycles: `dac_sclk`=0. `dac_sout` holds bit `bit`. Then go to HIGH.
- HIGH, H cycles: `dac_sclk`=1. The DAC samples on the rising edge.
  - On exit with bit<WORD_W-1: shift left, bit+1, go to LOW. `dac_sout` changes only at HIGH→LOW.
  - On exit with bit=WORD_W-1: go to GAP.
- GAP, 2H cycles: `dac_sync`=1, `dac_sclk`=1, `dac_sout`=0.
  - On exit with ch<NUM_CH-1: ch+1, load the next word, go to LOAD.
  - Otherwise go to IDLE.
- `done`=1 in the first IDLE cycle after GAP; `busy` is 0 in that cycle.
- Handshake rules:
  - `start` while busy is ignored, with no queueing.
  - `start` in the `done` cycle is accepted, giving back-to-back transfers.
  - `start` held high restarts on every IDLE cycle.
- Changes to `ch_data` while busy have no effect on the transfer in progress.
- Reset mid-transfer aborts immediately to the idle pin levels. No `done` is produced. The DAC discards the partial frame because `sync` rises before the last sampling edge.

## Timing
- Accept edge k: `busy`=1 and `dac_sync`=0 from cycle k+1.
- Frame length with `sync` low: H + 2H·WORD_W cycles.
- Inter-frame `sync`-high gap: 2H cycles.
- Total accept-to-`done`: NUM_CH·(3H + 2H·WORD_W) cycles. With defaults that is 2·(6+64) = 140 cycles, so `done` is at k+141.
- `dac_sout` setup to the `dac_sclk` rising edge is H cycles; hold is H cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DAC_SPI_AUTO_EN` defined:
  - continuous mode: on leaving the final GAP the block re-latches `ch_data` and goes straight to LOAD for ch=0
  - `start` is ignored
  - `done` still pulses for one cycle, coincident with the re-latch
  - `busy` stays 1 after the first accept, until reset
- Not defined: single-shot behaviour exactly as described above.

## Test plan
- Reset, then idle for 20 cycles → `dac_sync`=1, `dac_sclk`=1, `dac_sout`=0, `busy`=0, `done`=0 throughout.
- Defaults, `ch_data`={16'h3C5A, 16'h03A5}, one-cycle `start`:
  - the bench samples `dac_sout` on each `dac_sclk` rise and sees frame 16'h03A5 then frame 16'h3C5A
  - each frame has exactly 16 rising edges with `dac_sync` low
  - the `sync` gap is 4 cycles
  - `done` is at k+141
- `start` pulsed while busy at cycle k+50, with `ch_data` changed at k+10 → the transfer is unchanged and there is exactly one `done`.
- `start` held high through `done` → the second transfer's `dac_sync` falls at done+1, with no missing or extra frames.
- `rst_n` low at cycle k+30 → all outputs are at idle levels within the same cycle, with no `done`. A later `start` works normally.
- With `WORD_W`=24, `NUM_CH`=4, `CLK_DIV`=1, plus `DAC_SPI_AUTO_EN` run for 3 rounds → each frame has 24 bits, `done` repeats every 4·(3+48) = 204 cycles, and each round carries the updated `ch_data`.
